// File: rtl/ibis_pkg.sv
// Shared types and constants for the ibis affine texture mapper.
package ibis_pkg;

    // Out-of-tile handling; the reserved encoding behaves as stencil.
    typedef enum logic [1:0] {
        MAP_STENCIL = 2'd0,
        MAP_WRAP    = 2'd1,
        MAP_CLAMP   = 2'd2,
        MAP_RSVD    = 2'd3
    } map_mode_t;

    // Bit positions of cfg_sel: {Ty,Tx,D,C,B,A}.
    localparam int CFG_NUM    = 6;
    localparam int CFG_SEL_A  = 0;
    localparam int CFG_SEL_B  = 1;
    localparam int CFG_SEL_C  = 2;
    localparam int CFG_SEL_D  = 3;
    localparam int CFG_SEL_TX = 4;
    localparam int CFG_SEL_TY = 5;

    // Reset configuration is the identity transform in stencil mode.
    localparam map_mode_t MODE_RESET = MAP_STENCIL;

    // Diagonal matrix entries reset to 1.0, everything else to 0.
    function automatic logic is_diag_entry(input int idx);
        return (idx == CFG_SEL_A) || (idx == CFG_SEL_D);
    endfunction

    // Collapse the reserved encoding onto stencil.
    function automatic map_mode_t effective_mode(input map_mode_t m);
        case (m)
            MAP_WRAP:  return MAP_WRAP;
            MAP_CLAMP: return MAP_CLAMP;
            default:   return MAP_STENCIL;
        endcase
    endfunction

endpackage

// File: rtl/ibis_affine_lane.sv
// One axis of the affine transform: S1 multiplies, S2 sums and adds the
// half-tile offset so the tile origin lands in the tile centre.
module ibis_affine_lane #(
    parameter int MAT_W          = 12,
    parameter int FRAC_BITS      = 4,
    parameter int TILE_SIZE_POW2 = 5
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 adv_i,
    input  logic [MAT_W-1:0]     ca_i,
    input  logic [MAT_W-1:0]     cb_i,
    input  logic [MAT_W:0]       xs_i,
    input  logic [MAT_W:0]       ys_i,
    output logic [2*MAT_W+1:0]   sum_o
);

    localparam int PW = 2 * MAT_W + 1;
    localparam int SW = PW + 1;
    localparam int HS = TILE_SIZE_POW2 - 1 + 2 * FRAC_BITS;
    localparam logic [SW-1:0] HALF = {{(SW-HS-1){1'b0}}, 1'b1, {HS{1'b0}}};

    logic signed [PW-1:0] prod_a_d, prod_b_d, prod_a_q, prod_b_q;
    logic signed [SW-1:0] sum_d, sum_q;

    // Full-width signed products and the widened sum; operands are sign
    // extended to product width so the multiply is exact.
    always_comb begin
        prod_a_d = $signed({{(PW-MAT_W){ca_i[MAT_W-1]}}, ca_i})
                 * $signed({{(PW-MAT_W-1){xs_i[MAT_W]}}, xs_i});
        prod_b_d = $signed({{(PW-MAT_W){cb_i[MAT_W-1]}}, cb_i})
                 * $signed({{(PW-MAT_W-1){ys_i[MAT_W]}}, ys_i});
        sum_d    = $signed({prod_a_q[PW-1], prod_a_q})
                 + $signed({prod_b_q[PW-1], prod_b_q})
                 + $signed(HALF);
    end

    // S1/S2 registers, frozen together with the rest of the pipe on stall.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prod_a_q <= {PW{1'b0}};
            prod_b_q <= {PW{1'b0}};
            sum_q    <= {SW{1'b0}};
        end else if (adv_i) begin
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
            sum_q    <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ibis_affine_mapper_pipe.sv
// Fully pipelined affine texture mapper: screen (x,y) -> tile texel address,
// one pixel per clock, double-buffered configuration with drain-then-swap commit.
module ibis_affine_mapper_pipe
    import ibis_pkg::*;
#(
    parameter int TILE_SIZE_POW2 = 5,
    parameter int WIDTH          = 10,
    parameter int COORD_BITS     = 7,
    parameter int MAT_W          = 12,
    parameter int FRAC_BITS      = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_we,
    input  logic [CFG_NUM-1:0]          cfg_sel,
    input  logic [MAT_W-1:0]            cfg_data,
    input  logic                        cfg_mode_we,
    input  logic [1:0]                  cfg_mode,
    input  logic                        cfg_commit,
    output logic                        cfg_busy,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WIDTH-1:0]            x,
    input  logic [WIDTH-1:0]            y,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [2*TILE_SIZE_POW2-1:0] map_address,
    output logic                        stencil_test
);

    localparam int T  = TILE_SIZE_POW2;
    localparam int XW = MAT_W + 1;
    localparam int SW = 2 * MAT_W + 2;
    localparam int IW = SW - 2 * FRAC_BITS;
    localparam logic [MAT_W-1:0] ONE  = {{(MAT_W-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [MAT_W-1:0] ZERO = {MAT_W{1'b0}};

    // Configuration state
    logic [MAT_W-1:0] sh_q  [CFG_NUM];
    logic [MAT_W-1:0] sh_d  [CFG_NUM];
    logic [MAT_W-1:0] act_q [CFG_NUM];
    logic [MAT_W-1:0] act_d [CFG_NUM];
    map_mode_t        sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic             busy_q, busy_d;

    // Pipeline state
    logic                 s0v_q, s1v_q, s2v_q, mv_q;
    logic signed [XW-1:0] xs_d, ys_d, xs_q, ys_q;
    logic [2*T-1:0]       addr_d, addr_q;
    logic                 stn_d, stn_q;

    logic                 advance_s, accept_s, ready_s, drained_s;
    logic [SW-1:0]        sum_u_s, sum_v_s;
    logic [IW-1:0]        u_int_s, v_int_s;
    map_mode_t            eff_mode_s;
    logic                 unused_bits_s;

    function automatic logic in_range(input logic [IW-1:0] iv);
        return ~|iv[IW-1:T];
    endfunction

    function automatic logic [T-1:0] resolve_axis(input logic [IW-1:0] iv, input map_mode_t mode);
        logic [T-1:0] r;
        case (mode)
            MAP_CLAMP: begin
                if (iv[IW-1])           r = {T{1'b0}};
                else if (|iv[IW-2:T])   r = {T{1'b1}};
                else                    r = iv[T-1:0];
            end
            default:                    r = iv[T-1:0];
        endcase
        return r;
    endfunction

    assign advance_s = !mv_q || m_ready;
    assign ready_s   = advance_s && !busy_q;
    assign accept_s  = s_valid && ready_s;
    assign drained_s = !(s0v_q || s1v_q || s2v_q);

    // Shadow register file: writes land any cycle, multi-hot selects write all.
    always_comb begin
        sh_d = sh_q;
        for (int i = 0; i < CFG_NUM; i++) begin
            if (cfg_we && cfg_sel[i]) sh_d[i] = cfg_data;
            else                      sh_d[i] = sh_q[i];
        end
        if (cfg_mode_we) sh_mode_d = map_mode_t'(cfg_mode);
        else             sh_mode_d = sh_mode_q;
    end

    // Commit sequencing: hold off input, wait for S0-S2 to empty, then swap.
    // The output register may still hold a pixel, but it is already resolved.
    always_comb begin
        busy_d     = busy_q;
        act_d      = act_q;
        act_mode_d = act_mode_q;
        if (busy_q) begin
            if (drained_s) begin
                busy_d     = 1'b0;
                act_d      = sh_d;
                act_mode_d = sh_mode_d;
            end else begin
                busy_d     = 1'b1;
            end
        end else begin
            busy_d = cfg_commit;
        end
    end

    // Configuration registers with identity reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < CFG_NUM; i++) begin
                sh_q[i]  <= is_diag_entry(i) ? ONE : ZERO;
                act_q[i] <= is_diag_entry(i) ? ONE : ZERO;
            end
            sh_mode_q  <= MODE_RESET;
            act_mode_q <= MODE_RESET;
            busy_q     <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            act_q      <= act_d;
            sh_mode_q  <= sh_mode_d;
            act_mode_q <= act_mode_d;
            busy_q     <= busy_d;
        end
    end

    // S0: tile-local fixed-point coordinate minus translate.
    always_comb begin
        xs_d = $signed({{(XW-COORD_BITS-FRAC_BITS){1'b0}}, x[COORD_BITS-1:0], {FRAC_BITS{1'b0}}})
             - $signed({act_q[CFG_SEL_TX][MAT_W-1], act_q[CFG_SEL_TX]});
        ys_d = $signed({{(XW-COORD_BITS-FRAC_BITS){1'b0}}, y[COORD_BITS-1:0], {FRAC_BITS{1'b0}}})
             - $signed({act_q[CFG_SEL_TY][MAT_W-1], act_q[CFG_SEL_TY]});
    end

    ibis_affine_lane #(
        .MAT_W          (MAT_W),
        .FRAC_BITS      (FRAC_BITS),
        .TILE_SIZE_POW2 (TILE_SIZE_POW2)
    ) u_lane_u (
        .aclk    (aclk),
        .aresetn (aresetn),
        .adv_i   (advance_s),
        .ca_i    (act_q[CFG_SEL_A]),
        .cb_i    (act_q[CFG_SEL_B]),
        .xs_i    (xs_q),
        .ys_i    (ys_q),
        .sum_o   (sum_u_s)
    );

    ibis_affine_lane #(
        .MAT_W          (MAT_W),
        .FRAC_BITS      (FRAC_BITS),
        .TILE_SIZE_POW2 (TILE_SIZE_POW2)
    ) u_lane_v (
        .aclk    (aclk),
        .aresetn (aresetn),
        .adv_i   (advance_s),
        .ca_i    (act_q[CFG_SEL_C]),
        .cb_i    (act_q[CFG_SEL_D]),
        .xs_i    (xs_q),
        .ys_i    (ys_q),
        .sum_o   (sum_v_s)
    );

    // S3: drop the fraction, then apply the out-of-tile mode.
    always_comb begin
        u_int_s    = sum_u_s[SW-1:2*FRAC_BITS];
        v_int_s    = sum_v_s[SW-1:2*FRAC_BITS];
        eff_mode_s = effective_mode(act_mode_q);
        addr_d     = {resolve_axis(v_int_s, eff_mode_s), resolve_axis(u_int_s, eff_mode_s)};
        if (eff_mode_s == MAP_STENCIL) stn_d = in_range(u_int_s) && in_range(v_int_s);
        else                           stn_d = 1'b1;
    end

    // Stage valids, S0 data and the output register; all move on advance only.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s0v_q  <= 1'b0;
            s1v_q  <= 1'b0;
            s2v_q  <= 1'b0;
            mv_q   <= 1'b0;
            xs_q   <= {XW{1'b0}};
            ys_q   <= {XW{1'b0}};
            addr_q <= {(2*T){1'b0}};
            stn_q  <= 1'b0;
        end else if (advance_s) begin
            s0v_q <= accept_s;
            s1v_q <= s0v_q;
            s2v_q <= s1v_q;
            mv_q  <= s2v_q;
            if (accept_s) begin
                xs_q <= xs_d;
                ys_q <= ys_d;
            end
            if (s2v_q) begin
                addr_q <= addr_d;
                stn_q  <= stn_d;
            end
        end
    end

    assign unused_bits_s = ^{x[WIDTH-1:COORD_BITS], y[WIDTH-1:COORD_BITS],
                             sum_u_s[2*FRAC_BITS-1:0], sum_v_s[2*FRAC_BITS-1:0]};

    assign s_ready      = ready_s;
    assign cfg_busy     = busy_q;
    assign m_valid      = mv_q;
    assign map_address  = addr_q;
    assign stencil_test = stn_q;

endmodule
